cyc_accounting_unit: RTL

CYC_ACCOUNTING_UNIT -- requirements
Module: cyc_accounting_unit

---
 rtl/config_pkg.sv | 12 +
 rtl/cyc_acc_pkg.sv | 31 +++
 rtl/riscv.sv | 10 +
 rtl/cyc_accounting_unit_if.sv | 25 ++
 rtl/cyc_acc_counter.sv | 55 +++++
 rtl/cyc_accounting_unit.sv | 189 ++++++++++++++++++
 6 files changed

// File: rtl/config_pkg.sv
// Core configuration subset needed by the cycle-accounting unit.
// Only the fields this block reads are carried; cva6_cfg_empty is the
// default configuration (64-bit core).
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64};

endpackage

// File: rtl/cyc_acc_pkg.sv
// Shared types for the cycle-accounting unit: STATUS and CTRL register
// layouts, CTRL bit positions and the largest supported counter count.
package cyc_acc_pkg;

    localparam int unsigned MAX_NR_COUNTERS = 16;

    localparam int unsigned CTRL_RUN       = 0;
    localparam int unsigned CTRL_HW_MODE   = 1;
    localparam int unsigned CTRL_VIEW_SNAP = 2;
    localparam int unsigned CTRL_SNAP      = 3;
    localparam int unsigned CTRL_CLR       = 4;
    localparam int unsigned CTRL_IRQ_EN    = 5;

    // STATUS: [31:16] active index, [15:0] read/write target index
    typedef struct packed {
        logic [15:0] en;
        logic [15:0] sel;
    } status_t;

    // CTRL: snap and clr are write pulses and are never stored
    typedef struct packed {
        logic [25:0] rsvd;
        logic        irq_en;
        logic        clr;
        logic        snap;
        logic        view_snap;
        logic        hw_mode;
        logic        run;
    } ctrl_t;

endpackage

// File: rtl/riscv.sv
// CSR address map entries used by the cycle-accounting unit.
package riscv;

    localparam logic [11:0] CSR_CNT_DATA   = 12'h7C0;
    localparam logic [11:0] CSR_CNT_DATA_H = 12'h7C1;
    localparam logic [11:0] CSR_CNT_STATUS = 12'h7C2;
    localparam logic [11:0] CSR_CNT_CTRL   = 12'h7C3;
    localparam logic [11:0] CSR_CNT_OVF    = 12'h7C4;

endpackage

// File: rtl/cyc_accounting_unit_if.sv
// CSR access bus of the cycle-accounting unit.
//   addr_i  : 12-bit CSR address
//   we_i    : write strobe
//   data_i  : write data (XLEN)
//   data_o  : combinational read data for addr_i (XLEN)
//   ex_o    : combinational access exception for the current address
interface cyc_accounting_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic [11:0]     addr_i;
    logic            we_i;
    logic [XLEN-1:0] data_i;
    logic [XLEN-1:0] data_o;
    logic            ex_o;

    modport master (
        output addr_i, we_i, data_i,
        input  data_o, ex_o
    );

    modport slave (
        input  addr_i, we_i, data_i,
        output data_o, ex_o
    );
endinterface

// File: rtl/cyc_acc_counter.sv
// One accounting counter with its shadow copy.
//   clr_i            : zero the live counter (highest priority)
//   wr_i/wr_mask_i/wr_val_i : replace the masked bits of the live counter
//   inc_i            : add one (ignored when clearing or writing)
//   snap_i           : copy the pre-update live value into the shadow
//   cnt_o/shadow_o   : live and shadow values
//   wrap_o           : this edge takes the counter from all-ones to zero
module cyc_acc_counter #(
    parameter int unsigned CntWidth = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                snap_i,
    input  logic                inc_i,
    input  logic                wr_i,
    input  logic [CntWidth-1:0] wr_mask_i,
    input  logic [CntWidth-1:0] wr_val_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic [CntWidth-1:0] shadow_o,
    output logic                wrap_o
);
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] shadow_q, shadow_d;

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        wrap_o   = 1'b0;
        if (snap_i) begin
            shadow_d = cnt_q;
        end
        if (clr_i) begin
            cnt_d = '0;
        end else if (wr_i) begin
            cnt_d = (cnt_q & ~wr_mask_i) | (wr_val_i & wr_mask_i);
        end else if (inc_i) begin
            cnt_d  = cnt_q + CntWidth'(1);
            wrap_o = &cnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign shadow_o = shadow_q;
endmodule

// File: rtl/cyc_accounting_unit.sv
// Cycle-accounting unit: NrCounters cycle counters, one of which (the
// active index) counts every cycle while running, with snapshot shadows,
// sticky overflow flags and an overflow interrupt, all behind a small CSR
// window (DATA, DATA_H, STATUS, CTRL, OVF).
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   debug_mode_i   : freezes counting while high
//   ctx_i          : hardware-supplied active index (used when hw_mode=1)
//   irq_o          : registered overflow interrupt
//   csr            : CSR access bus (address, write strobe/data, read data,
//                    access exception)
module cyc_accounting_unit
    import cyc_acc_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg    = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NrCounters = 8,
    parameter int unsigned           CntWidth   = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          debug_mode_i,
    input  logic [$clog2(NrCounters)-1:0] ctx_i,
    output logic                          irq_o,
    cyc_accounting_unit_if.slave          csr
);
    localparam int unsigned XLEN = CVA6Cfg.XLEN;

    logic hit_data, hit_data_h, hit_status, hit_ctrl, hit_ovf, acc_ok;
    logic wr_cnt, wr_status, wr_ctrl, wr_ovf;
    logic snap_pulse, clr_pulse;

    status_t status_q, status_d, status_new;
    ctrl_t   ctrl_q, ctrl_d;
    logic [NrCounters-1:0] ovf_q, ovf_d;
    logic irq_q, irq_d;

    logic [15:0] act_idx;
    logic        count_en;
    logic [63:0] wdata64, wr_mask64, wr_val64;

    logic [CntWidth-1:0]   live   [NrCounters];
    logic [CntWidth-1:0]   shadow [NrCounters];
    logic [NrCounters-1:0] wrap;
    logic [CntWidth-1:0]   rd_live, rd_shadow, rd_cnt;
    logic [63:0]           cnt64;

    // DATA_H exists only on 32-bit cores, where it holds the upper half.
    always_comb begin
        hit_data   = csr.addr_i == riscv::CSR_CNT_DATA;
        hit_data_h = (XLEN == 32) && (csr.addr_i == riscv::CSR_CNT_DATA_H);
        hit_status = csr.addr_i == riscv::CSR_CNT_STATUS;
        hit_ctrl   = csr.addr_i == riscv::CSR_CNT_CTRL;
        hit_ovf    = csr.addr_i == riscv::CSR_CNT_OVF;
        acc_ok     = hit_data | hit_data_h | hit_status | hit_ctrl | hit_ovf;
    end

    assign csr.ex_o = ~acc_ok;

    assign wr_cnt     = csr.we_i & (hit_data | hit_data_h);
    assign wr_status  = csr.we_i & hit_status;
    assign wr_ctrl    = csr.we_i & hit_ctrl;
    assign wr_ovf     = csr.we_i & hit_ovf;
    assign snap_pulse = wr_ctrl & csr.data_i[CTRL_SNAP];
    assign clr_pulse  = wr_ctrl & csr.data_i[CTRL_CLR];

    // STATUS update is all-or-nothing: an out-of-range index rejects the
    // whole write silently.
    always_comb begin
        status_new = status_t'(csr.data_i[31:0]);
        status_d   = status_q;
        if (wr_status && (32'(status_new.sel) < NrCounters)
                      && (32'(status_new.en) < NrCounters)) begin
            status_d = status_new;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d      = ctrl_t'(csr.data_i[31:0]);
            ctrl_d.rsvd = '0;
            ctrl_d.snap = 1'b0;
            ctrl_d.clr  = 1'b0;
        end
    end

    // An out-of-range ctx_i simply matches no counter.
    always_comb begin
        act_idx  = ctrl_q.hw_mode ? 16'(ctx_i) : status_q.en;
        count_en = ctrl_q.run & ~debug_mode_i & (32'(act_idx) < NrCounters);
    end

    // On a 64-bit core DATA covers the whole counter; on a 32-bit core DATA
    // and DATA_H cover the low and high words. Bits above CntWidth fall off
    // when the mask and value are truncated to the counter width.
    always_comb begin
        wdata64 = 64'(csr.data_i);
        if (XLEN == 64) begin
            wr_mask64 = '1;
            wr_val64  = wdata64;
        end else if (hit_data_h) begin
            wr_mask64 = 64'hFFFF_FFFF_0000_0000;
            wr_val64  = wdata64 << 32;
        end else begin
            wr_mask64 = 64'h0000_0000_FFFF_FFFF;
            wr_val64  = wdata64;
        end
    end

    for (genvar i = 0; i < NrCounters; i++) begin : g_cnt
        logic sel_hit, act_hit;
        assign sel_hit = wr_cnt && (status_q.sel == 16'(i));
        assign act_hit = count_en && (act_idx == 16'(i));

        cyc_acc_counter #(
            .CntWidth (CntWidth)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .clr_i     (clr_pulse),
            .snap_i    (snap_pulse),
            .inc_i     (act_hit),
            .wr_i      (sel_hit),
            .wr_mask_i (wr_mask64[CntWidth-1:0]),
            .wr_val_i  (wr_val64[CntWidth-1:0]),
            .cnt_o     (live[i]),
            .shadow_o  (shadow[i]),
            .wrap_o    (wrap[i])
        );
    end

    // A wrap in the same cycle as a W1C clear keeps its bit set.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_ovf) begin
            ovf_d = ovf_q & ~csr.data_i[NrCounters-1:0];
        end
        ovf_d = ovf_d | wrap;
        if (clr_pulse) begin
            ovf_d = '0;
        end
        irq_d = (|ovf_d) & ctrl_q.irq_en;
    end

    always_comb begin
        rd_live   = '0;
        rd_shadow = '0;
        for (int i = 0; i < int'(NrCounters); i++) begin
            if (status_q.sel == 16'(i)) begin
                rd_live   = live[i];
                rd_shadow = shadow[i];
            end
        end
        rd_cnt = ctrl_q.view_snap ? rd_shadow : rd_live;
        cnt64  = 64'(rd_cnt);
    end

    // Read data always reflects current register state, so a read during
    // a write returns the pre-write value.
    always_comb begin
        csr.data_o = '0;
        if (hit_data) begin
            csr.data_o = cnt64[XLEN-1:0];
        end else if (hit_data_h) begin
            csr.data_o = XLEN'(cnt64 >> 32);
        end else if (hit_status) begin
            csr.data_o = XLEN'(status_q);
        end else if (hit_ctrl) begin
            csr.data_o = XLEN'(ctrl_q);
        end else if (hit_ovf) begin
            csr.data_o = XLEN'(ovf_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_q <= '0;
            ctrl_q   <= '0;
            ovf_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o = irq_q;
endmodule
